// File: rtl/multicycle_sequencer_pkg.sv
// Shared encodings for the multicycle sequencer: states, opcodes, ALU classes, PC sources.
package multicycle_sequencer_pkg;

  typedef enum logic [2:0] {
    st_idle   = 3'd0,
    st_fetch  = 3'd1,
    st_decode = 3'd2,
    st_exec   = 3'd3,
    st_mem    = 3'd4,
    st_wb     = 3'd5
  } state_e;

  localparam logic [3:0] op_r    = 4'b0000;
  localparam logic [3:0] op_lw   = 4'b0001;
  localparam logic [3:0] op_sw   = 4'b0010;
  localparam logic [3:0] op_beq  = 4'b0011;
  localparam logic [3:0] op_bne  = 4'b0100;
  localparam logic [3:0] op_jump = 4'b0111;

  localparam logic [2:0] alu_none   = 3'b000;
  localparam logic [2:0] alu_mem    = 3'b001;
  localparam logic [2:0] alu_branch = 3'b010;
  localparam logic [2:0] alu_func   = 3'b100;

  localparam logic [1:0] pc_inc    = 2'b00;
  localparam logic [1:0] pc_branch = 2'b01;
  localparam logic [1:0] pc_jump   = 2'b10;

  function automatic logic is_legal(input logic [3:0] op);
    return (op == op_r) || (op == op_lw) || (op == op_sw) ||
           (op == op_beq) || (op == op_bne) || (op == op_jump);
  endfunction

endpackage

// File: rtl/multicycle_sequencer_timer.sv
// Memory wait counter: counts stalled cycles, flags the last allowed one.
module mem_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int cw = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [cw-1:0] last = cw'(TIMEOUT - 1);

  logic [cw-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (en)
      count <= count + 1'b1;
  end

  assign expired = (count == last);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle CPU control sequencer with bounded memory waits.
// state  | meaning
// IDLE   | stopped, waiting for start at a boundary
// FETCH  | instruction read from PC, waits for mem_ready
// DECODE | opcode latched; jumps and illegal opcodes finish here
// EXEC   | ALU step; branches finish here
// MEM    | data access at ALU address, waits for mem_ready
// WB     | register file write
module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [2:0] state,
  output logic       busy,
  output logic       err,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic [2:0] alu_op,
  output logic       alu_src,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write
);

  state_e     state_q, state_d, boundary;
  logic [3:0] op_q;
  logic       waiting, expired, timeout;

  assign waiting  = (state_q == st_fetch) || (state_q == st_mem);
  assign timeout  = waiting && expired && !mem_ready;
  assign boundary = start ? st_fetch : st_idle;

  // Cleared whenever not stalled, so every FETCH/MEM entry starts at zero.
  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (!waiting || mem_ready || expired),
    .en     (waiting && !mem_ready),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= st_idle;
      op_q    <= op_r;
    end else begin
      state_q <= state_d;
      if (state_q == st_decode)
        op_q <= opcode;
    end
  end

  always_comb begin
    state_d    = state_q;
    err        = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = pc_inc;
    alu_op     = alu_none;
    alu_src    = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    case (state_q)
      st_idle: begin
        if (start)
          state_d = st_fetch;
      end
      st_fetch: begin
        mem_req = !timeout;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = st_decode;
        end else if (expired) begin
          err     = 1'b1;
          state_d = st_idle;
        end
      end
      // Decisions here use the live opcode; op_q only becomes valid afterwards.
      st_decode: begin
        if (opcode == op_jump) begin
          pc_write = 1'b1;
          pc_src   = pc_jump;
          state_d  = boundary;
        end else if (!is_legal(opcode)) begin
          err     = 1'b1;
          state_d = boundary;
        end else begin
          state_d = st_exec;
        end
      end
      st_exec: begin
        case (op_q)
          op_lw, op_sw: begin
            alu_op  = alu_mem;
            alu_src = 1'b1;
            state_d = st_mem;
          end
          op_r: begin
            alu_op  = alu_func;
            state_d = st_wb;
          end
          op_beq, op_bne: begin
            alu_op   = alu_branch;
            pc_src   = pc_branch;
            pc_write = (op_q == op_beq) ? zero : !zero;
            state_d  = boundary;
          end
          default: state_d = st_idle;
        endcase
      end
      st_mem: begin
        mem_req = !timeout;
        iord    = 1'b1;
        mem_we  = (op_q == op_sw);
        if (mem_ready)
          state_d = (op_q == op_sw) ? boundary : st_wb;
        else if (expired) begin
          err     = 1'b1;
          state_d = st_idle;
        end
      end
      st_wb: begin
        reg_write = 1'b1;
        if (op_q == op_lw)
          mem_to_reg = 1'b1;
        else
          reg_dst = 1'b1;
        state_d = boundary;
      end
      default: state_d = st_idle;
    endcase
  end

  assign state = state_q;
  assign busy  = (state_q != st_idle);

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: queued per-cycle stimulus with expected state/controls.
module tb_multicycle_sequencer;

  localparam logic [3:0] o_r = 4'b0000, o_lw = 4'b0001, o_sw = 4'b0010;
  localparam logic [3:0] o_beq = 4'b0011, o_bne = 4'b0100, o_jmp = 4'b0111, o_bad = 4'b1111;

  logic clk = 1'b0;
  logic rst_n, start, zero, mem_ready;
  logic [3:0] opcode;
  logic [2:0] state, alu_op;
  logic [1:0] pc_src;
  logic busy, err, mem_req, mem_we, iord, ir_write, pc_write, alu_src, reg_dst, mem_to_reg, reg_write;

  multicycle_sequencer #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .state(state), .busy(busy), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .alu_op(alu_op), .alu_src(alu_src),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write)
  );

  always #5 clk = ~clk;

  logic [15:0] ctl_obs;
  assign ctl_obs = {busy, err, mem_req, mem_we, iord, ir_write, pc_write, pc_src,
                    alu_op, alu_src, reg_dst, mem_to_reg, reg_write};

  typedef struct {
    logic        start;
    logic [3:0]  opc;
    logic        zero;
    logic        rdy;
    logic [2:0]  st;
    logic [15:0] ctl;
  } step_t;

  step_t q[$];
  int checks = 0;
  int failures = 0;
  string phase = "reset";

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] c(input logic b, e, req, we, io, irw, pcw,
                                    input logic [1:0] pcs, input logic [2:0] alu,
                                    input logic asrc, rdst, m2r, rw);
    return {b, e, req, we, io, irw, pcw, pcs, alu, asrc, rdst, m2r, rw};
  endfunction

  logic [15:0] f_wait, f_done, f_to, dec, dec_j, dec_ill, ex_r, ex_m, ex_bt, ex_bn;
  logic [15:0] m_lw, m_sw, wb_r, wb_lw;

  task automatic push(input logic s, input logic [3:0] o, input logic z, input logic r,
                      input logic [2:0] st, input logic [15:0] ct);
    step_t t;
    t.start = s; t.opc = o; t.zero = z; t.rdy = r; t.st = st; t.ctl = ct;
    q.push_back(t);
  endtask

  task automatic drain();
    step_t t;
    while (q.size() > 0) begin
      t = q.pop_front();
      @(negedge clk);
      start = t.start; opcode = t.opc; zero = t.zero; mem_ready = t.rdy;
      #1;
      chk({phase, ".state"}, 32'(state), 32'(t.st));
      chk({phase, ".ctl"}, 32'(ctl_obs), 32'(t.ctl));
    end
  endtask

  initial begin
    f_wait  = c(1,0,1,0,0,0,0,2'b00,3'b000,0,0,0,0);
    f_done  = c(1,0,1,0,0,1,1,2'b00,3'b000,0,0,0,0);
    f_to    = c(1,1,0,0,0,0,0,2'b00,3'b000,0,0,0,0);
    dec     = c(1,0,0,0,0,0,0,2'b00,3'b000,0,0,0,0);
    dec_j   = c(1,0,0,0,0,0,1,2'b10,3'b000,0,0,0,0);
    dec_ill = c(1,1,0,0,0,0,0,2'b00,3'b000,0,0,0,0);
    ex_r    = c(1,0,0,0,0,0,0,2'b00,3'b100,0,0,0,0);
    ex_m    = c(1,0,0,0,0,0,0,2'b00,3'b001,1,0,0,0);
    ex_bt   = c(1,0,0,0,0,0,1,2'b01,3'b010,0,0,0,0);
    ex_bn   = c(1,0,0,0,0,0,0,2'b01,3'b010,0,0,0,0);
    m_lw    = c(1,0,1,0,1,0,0,2'b00,3'b000,0,0,0,0);
    m_sw    = c(1,0,1,1,1,0,0,2'b00,3'b000,0,0,0,0);
    wb_r    = c(1,0,0,0,0,0,0,2'b00,3'b000,0,1,0,1);
    wb_lw   = c(1,0,0,0,0,0,0,2'b00,3'b000,0,0,1,1);

    rst_n = 1'b0; start = 1'b1; opcode = o_lw; zero = 1'b1; mem_ready = 1'b1;
    #7;
    chk("reset.state", 32'(state), 32'd0);
    chk("reset.ctl", 32'(ctl_obs), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; start = 1'b0;

    phase = "idle";
    push(0, o_r, 0, 1, 3'd0, 16'h0);
    push(0, o_r, 0, 0, 3'd0, 16'h0);
    drain();

    phase = "rtype";
    push(1, o_r, 0, 1, 3'd0, 16'h0);
    push(1, o_r, 0, 1, 3'd1, f_done);
    push(1, o_r, 0, 1, 3'd2, dec);
    push(1, o_r, 0, 1, 3'd3, ex_r);
    push(1, o_r, 0, 1, 3'd5, wb_r);
    drain();

    phase = "lw";
    push(1, o_lw, 0, 1, 3'd1, f_done);
    push(1, o_lw, 0, 1, 3'd2, dec);
    push(1, o_lw, 0, 1, 3'd3, ex_m);
    for (int i = 0; i < 3; i++) push(1, o_lw, 0, 0, 3'd4, m_lw);
    push(1, o_lw, 0, 1, 3'd4, m_lw);
    push(1, o_lw, 0, 1, 3'd5, wb_lw);
    drain();

    phase = "sw";
    push(1, o_sw, 0, 1, 3'd1, f_done);
    push(1, o_sw, 0, 1, 3'd2, dec);
    push(1, o_sw, 0, 1, 3'd3, ex_m);
    push(1, o_sw, 0, 1, 3'd4, m_sw);
    drain();

    phase = "branch";
    push(1, o_beq, 1, 1, 3'd1, f_done); push(1, o_beq, 1, 1, 3'd2, dec); push(1, o_beq, 1, 1, 3'd3, ex_bt);
    push(1, o_bne, 1, 1, 3'd1, f_done); push(1, o_bne, 1, 1, 3'd2, dec); push(1, o_bne, 1, 1, 3'd3, ex_bn);
    push(1, o_bne, 0, 1, 3'd1, f_done); push(1, o_bne, 0, 1, 3'd2, dec); push(1, o_bne, 0, 1, 3'd3, ex_bt);
    push(1, o_beq, 0, 1, 3'd1, f_done); push(1, o_beq, 0, 1, 3'd2, dec); push(1, o_beq, 0, 1, 3'd3, ex_bn);
    drain();

    phase = "jump_ill";
    push(1, o_jmp, 0, 1, 3'd1, f_done); push(1, o_jmp, 0, 1, 3'd2, dec_j);
    push(1, o_bad, 0, 1, 3'd1, f_done); push(1, o_bad, 0, 1, 3'd2, dec_ill);
    drain();

    phase = "timeout";
    for (int i = 0; i < 15; i++) push(1, o_r, 0, 0, 3'd1, f_wait);
    push(1, o_r, 0, 0, 3'd1, f_to);
    push(1, o_r, 0, 0, 3'd0, 16'h0);
    for (int i = 0; i < 15; i++) push(1, o_r, 0, 0, 3'd1, f_wait);
    push(1, o_r, 0, 1, 3'd1, f_done);
    push(0, o_jmp, 0, 0, 3'd2, dec_j);
    push(0, o_r, 0, 1, 3'd0, 16'h0);
    drain();

    phase = "stop_mid";
    push(1, o_r, 0, 0, 3'd0, 16'h0);
    push(0, o_r, 0, 1, 3'd1, f_done);
    push(0, o_r, 0, 0, 3'd2, dec);
    push(0, o_r, 0, 0, 3'd3, ex_r);
    push(0, o_r, 0, 0, 3'd5, wb_r);
    push(0, o_r, 0, 0, 3'd0, 16'h0);
    drain();

    phase = "sw_reset";
    push(1, o_sw, 0, 0, 3'd0, 16'h0);
    push(1, o_sw, 0, 1, 3'd1, f_done);
    push(1, o_sw, 0, 0, 3'd2, dec);
    push(1, o_sw, 0, 0, 3'd3, ex_m);
    push(1, o_sw, 0, 0, 3'd4, m_sw);
    drain();
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst.state", 32'(state), 32'd0);
    chk("async_rst.mem_req", 32'(mem_req), 32'd0);
    chk("async_rst.mem_we", 32'(mem_we), 32'd0);
    chk("async_rst.busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; start = 1'b0;

    phase = "restart";
    push(0, o_r, 0, 0, 3'd0, 16'h0);
    push(1, o_r, 0, 0, 3'd0, 16'h0);
    push(1, o_r, 0, 0, 3'd1, f_wait);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
